// File: rtl/csr_cmd_issuer.sv
// WB-stage CSR command issuer: sequences CSR access, exception and ertn strobes plus redirect flush.
// Optional macro CSR_SIDE_EFFECT_FLUSH_EN adds a pc+4 refetch flush after writes to side-effect CSRs.
module csr_cmd_issuer #(
    parameter int          CSR_NUM_W = 14,
    parameter logic [5:0]  ECODE_INT = 6'h00
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_op,
    input  logic [CSR_NUM_W-1:0] in_csr_num,
    input  logic [31:0]          in_rj,
    input  logic [31:0]          in_rd,
    input  logic [31:0]          in_pc,
    input  logic                 in_ex,
    input  logic [5:0]           in_ecode,
    input  logic [8:0]           in_esubcode,
    input  logic [31:0]          in_vaddr,
    output logic [CSR_NUM_W-1:0] csr_num,
    output logic                 csr_re,
    output logic                 csr_we,
    output logic [31:0]          csr_wmask,
    output logic [31:0]          csr_wvalue,
    input  logic [31:0]          csr_rvalue,
    output logic                 wb_ex,
    output logic [31:0]          wb_pc,
    output logic [5:0]           wb_ecode,
    output logic [8:0]           wb_esubcode,
    output logic [31:0]          wb_vaddr,
    output logic                 ertn_flush,
    input  logic [31:0]          ex_entry,
    input  logic [31:0]          ertn_pc,
    input  logic                 has_int,
    output logic                 rf_we,
    output logic [31:0]          rf_wdata,
    output logic                 flush,
    output logic [31:0]          flush_pc
);
    typedef enum logic [2:0] {
        S_IDLE, S_ACCESS, S_EXC, S_ERTN, S_REDIR, S_SEFLUSH
    } state_t;

    localparam logic [2:0] OP_CSRRD   = 3'd0;
    localparam logic [2:0] OP_CSRWR   = 3'd1;
    localparam logic [2:0] OP_CSRXCHG = 3'd2;
    localparam logic [2:0] OP_ERTN    = 3'd3;

    state_t               r_state;
    logic [CSR_NUM_W-1:0] r_csr_num;
    logic                 r_csr_re;
    logic                 r_csr_we;
    logic [31:0]          r_wmask;
    logic [31:0]          r_wvalue;
    logic                 r_rf_we;
    logic                 r_wb_ex;
    logic [31:0]          r_wb_pc;
    logic [5:0]           r_wb_ecode;
    logic [8:0]           r_wb_esub;
    logic [31:0]          r_wb_vaddr;
    logic                 r_ertn_flush;
    logic                 r_flush;
    logic                 r_redir_ertn;

    logic w_accept;
    logic w_is_access;
    logic w_is_ertn;

    assign w_accept    = in_valid && (r_state == S_IDLE);
    assign w_is_access = (in_op == OP_CSRRD) || (in_op == OP_CSRWR) || (in_op == OP_CSRXCHG);
    assign w_is_ertn   = (in_op == OP_ERTN);

`ifdef CSR_SIDE_EFFECT_FLUSH_EN
    logic        r_se_pend;
    logic [31:0] r_pc;
    logic        w_se_hit;

    // Writes that change interrupt/timer state must refetch so later instructions see them
    assign w_se_hit = ((in_op == OP_CSRWR) || (in_op == OP_CSRXCHG)) &&
                      ((in_csr_num == CSR_NUM_W'(14'h0))  || (in_csr_num == CSR_NUM_W'(14'h4))  ||
                       (in_csr_num == CSR_NUM_W'(14'h5))  || (in_csr_num == CSR_NUM_W'(14'h41)) ||
                       (in_csr_num == CSR_NUM_W'(14'h44)));
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state      <= S_IDLE;
            r_csr_num    <= '0;
            r_csr_re     <= 1'b0;
            r_csr_we     <= 1'b0;
            r_wmask      <= '0;
            r_wvalue     <= '0;
            r_rf_we      <= 1'b0;
            r_wb_ex      <= 1'b0;
            r_wb_pc      <= '0;
            r_wb_ecode   <= '0;
            r_wb_esub    <= '0;
            r_wb_vaddr   <= '0;
            r_ertn_flush <= 1'b0;
            r_flush      <= 1'b0;
            r_redir_ertn <= 1'b0;
`ifdef CSR_SIDE_EFFECT_FLUSH_EN
            r_se_pend    <= 1'b0;
            r_pc         <= '0;
`endif
        end else begin
            // Strobes are single-cycle: clear by default, set only on the entering transition
            r_csr_re     <= 1'b0;
            r_csr_we     <= 1'b0;
            r_wmask      <= '0;
            r_wvalue     <= '0;
            r_rf_we      <= 1'b0;
            r_wb_ex      <= 1'b0;
            r_wb_pc      <= '0;
            r_wb_ecode   <= '0;
            r_wb_esub    <= '0;
            r_wb_vaddr   <= '0;
            r_ertn_flush <= 1'b0;
            r_flush      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_csr_num <= in_csr_num;
`ifdef CSR_SIDE_EFFECT_FLUSH_EN
                        r_pc      <= in_pc;
                        r_se_pend <= 1'b0;
`endif
                        if (has_int) begin
                            r_state    <= S_EXC;
                            r_wb_ex    <= 1'b1;
                            r_wb_pc    <= in_pc;
                            r_wb_ecode <= ECODE_INT;
                            r_wb_esub  <= '0;
                            r_wb_vaddr <= in_vaddr;
                        end else if (in_ex) begin
                            r_state    <= S_EXC;
                            r_wb_ex    <= 1'b1;
                            r_wb_pc    <= in_pc;
                            r_wb_ecode <= in_ecode;
                            r_wb_esub  <= in_esubcode;
                            r_wb_vaddr <= in_vaddr;
                        end else if (w_is_access) begin
                            r_state  <= S_ACCESS;
                            r_csr_re <= 1'b1;
                            r_rf_we  <= 1'b1;
                            if (in_op != OP_CSRRD) begin
                                r_csr_we <= 1'b1;
                                r_wmask  <= (in_op == OP_CSRWR) ? 32'hFFFF_FFFF : in_rj;
                                r_wvalue <= in_rd;
                            end
`ifdef CSR_SIDE_EFFECT_FLUSH_EN
                            r_se_pend <= w_se_hit;
`endif
                        end else if (w_is_ertn) begin
                            r_state      <= S_ERTN;
                            r_ertn_flush <= 1'b1;
                        end
                    end
                end
                S_ACCESS: begin
`ifdef CSR_SIDE_EFFECT_FLUSH_EN
                    if (r_se_pend) begin
                        r_state <= S_SEFLUSH;
                        r_flush <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                    end
`else
                    r_state <= S_IDLE;
`endif
                end
                S_EXC: begin
                    r_state      <= S_REDIR;
                    r_flush      <= 1'b1;
                    r_redir_ertn <= 1'b0;
                end
                S_ERTN: begin
                    r_state      <= S_REDIR;
                    r_flush      <= 1'b1;
                    r_redir_ertn <= 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Redirect target is read in the flush cycle so it reflects the CSR update committed the cycle before
    always_comb begin
        flush_pc = 32'h0;
        if (r_flush) begin
`ifdef CSR_SIDE_EFFECT_FLUSH_EN
            if (r_state == S_SEFLUSH)
                flush_pc = r_pc + 32'd4;
            else
                flush_pc = r_redir_ertn ? ertn_pc : ex_entry;
`else
            flush_pc = r_redir_ertn ? ertn_pc : ex_entry;
`endif
        end
    end

    assign in_ready    = (r_state == S_IDLE);
    assign csr_num     = r_csr_num;
    assign csr_re      = r_csr_re;
    assign csr_we      = r_csr_we;
    assign csr_wmask   = r_wmask;
    assign csr_wvalue  = r_wvalue;
    assign wb_ex       = r_wb_ex;
    assign wb_pc       = r_wb_pc;
    assign wb_ecode    = r_wb_ecode;
    assign wb_esubcode = r_wb_esub;
    assign wb_vaddr    = r_wb_vaddr;
    assign ertn_flush  = r_ertn_flush;
    assign rf_we       = r_rf_we;
    assign rf_wdata    = r_rf_we ? csr_rvalue : 32'h0;
    assign flush       = r_flush;
endmodule

// File: tb/tb_csr_cmd_issuer.sv
// Directed bench for csr_cmd_issuer: per-cycle expected outputs queued at issue, popped and asserted per cycle.
module tb_csr_cmd_issuer;
    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid, in_ready;
    logic [2:0]  in_op;
    logic [13:0] in_csr_num, csr_num;
    logic [31:0] in_rj, in_rd, in_pc, in_vaddr;
    logic        in_ex;
    logic [5:0]  in_ecode, wb_ecode;
    logic [8:0]  in_esubcode, wb_esubcode;
    logic        csr_re, csr_we;
    logic [31:0] csr_wmask, csr_wvalue, csr_rvalue;
    logic        wb_ex, ertn_flush, has_int, rf_we, flush;
    logic [31:0] wb_pc, wb_vaddr, ex_entry, ertn_pc, rf_wdata, flush_pc;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        rdy, re, we;
        logic [31:0] wmask, wvalue;
        logic        rfwe;
        logic [31:0] rfwd;
        logic        wbex;
        logic [31:0] wbpc;
        logic [5:0]  ecode;
        logic [8:0]  esub;
        logic [31:0] vaddr;
        logic        ertn, fl;
        logic [31:0] flpc;
    } exp_t;

    exp_t exp_q[$];

    csr_cmd_issuer #(.CSR_NUM_W(14), .ECODE_INT(6'h00)) dut (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_csr_num(in_csr_num), .in_rj(in_rj), .in_rd(in_rd),
        .in_pc(in_pc), .in_ex(in_ex), .in_ecode(in_ecode), .in_esubcode(in_esubcode),
        .in_vaddr(in_vaddr), .csr_num(csr_num), .csr_re(csr_re), .csr_we(csr_we),
        .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue), .csr_rvalue(csr_rvalue),
        .wb_ex(wb_ex), .wb_pc(wb_pc), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode),
        .wb_vaddr(wb_vaddr), .ertn_flush(ertn_flush), .ex_entry(ex_entry),
        .ertn_pc(ertn_pc), .has_int(has_int), .rf_we(rf_we), .rf_wdata(rf_wdata),
        .flush(flush), .flush_pc(flush_pc)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    function automatic exp_t idle_exp();
        exp_t e;
        e = '{rdy: 1'b1, re: 1'b0, we: 1'b0, wmask: 32'h0, wvalue: 32'h0, rfwe: 1'b0,
              rfwd: 32'h0, wbex: 1'b0, wbpc: 32'h0, ecode: 6'h0, esub: 9'h0,
              vaddr: 32'h0, ertn: 1'b0, fl: 1'b0, flpc: 32'h0};
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        assert (act === expv) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, act, expv);
        end
    endtask

    task automatic check_cycle(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s got=empty_queue exp=entry", tag);
        end else begin
            e = exp_q.pop_front();
            chk({tag, ".in_ready"},   32'(in_ready),    32'(e.rdy));
            chk({tag, ".csr_re"},     32'(csr_re),      32'(e.re));
            chk({tag, ".csr_we"},     32'(csr_we),      32'(e.we));
            chk({tag, ".wmask"},      csr_wmask,        e.wmask);
            chk({tag, ".wvalue"},     csr_wvalue,       e.wvalue);
            chk({tag, ".rf_we"},      32'(rf_we),       32'(e.rfwe));
            chk({tag, ".rf_wdata"},   rf_wdata,         e.rfwd);
            chk({tag, ".wb_ex"},      32'(wb_ex),       32'(e.wbex));
            chk({tag, ".wb_pc"},      wb_pc,            e.wbpc);
            chk({tag, ".wb_ecode"},   32'(wb_ecode),    32'(e.ecode));
            chk({tag, ".wb_esub"},    32'(wb_esubcode), 32'(e.esub));
            chk({tag, ".wb_vaddr"},   wb_vaddr,         e.vaddr);
            chk({tag, ".ertn_flush"}, 32'(ertn_flush),  32'(e.ertn));
            chk({tag, ".flush"},      32'(flush),       32'(e.fl));
            chk({tag, ".flush_pc"},   flush_pc,         e.flpc);
        end
    endtask

    // Presents one op at a negedge, accepts it on the next posedge, returns #1 into cycle T+1
    task automatic issue(input logic [2:0] op, input logic [13:0] num, input logic [31:0] rj,
                         input logic [31:0] rd, input logic [31:0] pc, input logic ex,
                         input logic [5:0] ecode, input logic [8:0] esub,
                         input logic [31:0] vaddr, input logic hint);
        @(negedge clk);
        in_op = op; in_csr_num = num; in_rj = rj; in_rd = rd; in_pc = pc;
        in_ex = ex; in_ecode = ecode; in_esubcode = esub; in_vaddr = vaddr;
        has_int = hint; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        has_int = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t e;
        logic [13:0] exp_num;
        resetn = 1'b0; in_valid = 1'b0; in_op = 3'd4; in_csr_num = '0; in_rj = '0;
        in_rd = '0; in_pc = '0; in_ex = 1'b0; in_ecode = '0; in_esubcode = '0;
        in_vaddr = '0; has_int = 1'b0; csr_rvalue = 32'h0;
        ex_entry = 32'h1C00_8000; ertn_pc = 32'h1C00_0204;

        repeat (3) next_cycle();
        exp_q.push_back(idle_exp());
        check_cycle("reset");
        resetn = 1'b1;
        next_cycle();
        exp_q.push_back(idle_exp());
        check_cycle("post_reset");

        // csrwr
        csr_rvalue = 32'h0000_00A5;
        e = idle_exp(); e.rdy = 0; e.re = 1; e.we = 1; e.wmask = 32'hFFFF_FFFF;
        e.wvalue = 32'h1234_5678; e.rfwe = 1; e.rfwd = 32'h0000_00A5;
        exp_q.push_back(e);
        exp_q.push_back(idle_exp());
        exp_num = 14'h30;
        issue(3'd1, 14'h30, 32'h0, 32'h1234_5678, 32'h1C00_0000, 1'b0, 6'h0, 9'h0, 32'h0, 1'b0);
        check_cycle("csrwr.t1");
        chk("csrwr.csr_num", 32'(csr_num), 32'(exp_num));
        next_cycle();
        check_cycle("csrwr.t2");

        // csrxchg to ECFG
        e = idle_exp(); e.rdy = 0; e.re = 1; e.we = 1; e.wmask = 32'h0000_1FFF;
        e.wvalue = 32'h0000_0800; e.rfwe = 1; e.rfwd = 32'h0000_00A5;
        exp_q.push_back(e);
`ifdef CSR_SIDE_EFFECT_FLUSH_EN
        e = idle_exp(); e.rdy = 0; e.fl = 1; e.flpc = 32'h1C00_0014;
        exp_q.push_back(e);
        exp_q.push_back(idle_exp());
`else
        exp_q.push_back(idle_exp());
`endif
        issue(3'd2, 14'h4, 32'h0000_1FFF, 32'h0000_0800, 32'h1C00_0010, 1'b0, 6'h0, 9'h0, 32'h0, 1'b0);
        check_cycle("xchg.t1");
        next_cycle();
        check_cycle("xchg.t2");
`ifdef CSR_SIDE_EFFECT_FLUSH_EN
        next_cycle();
        check_cycle("xchg.t3");
`endif

        // exception; has_int raised afterwards must be ignored
        e = idle_exp(); e.rdy = 0; e.wbex = 1; e.wbpc = 32'h1C00_0100; e.ecode = 6'h09;
        e.esub = 9'h001; e.vaddr = 32'h8000_0003;
        exp_q.push_back(e);
        e = idle_exp(); e.rdy = 0; e.fl = 1; e.flpc = 32'h1C00_8000;
        exp_q.push_back(e);
        exp_q.push_back(idle_exp());
        issue(3'd4, 14'h0, 32'h0, 32'h0, 32'h1C00_0100, 1'b1, 6'h09, 9'h001, 32'h8000_0003, 1'b0);
        has_int = 1'b1;
        check_cycle("exc.t1");
        next_cycle();
        check_cycle("exc.t2");
        next_cycle();
        check_cycle("exc.t3");
        has_int = 1'b0;

        // interrupt beats both in_ex and the csrwr op
        e = idle_exp(); e.rdy = 0; e.wbex = 1; e.wbpc = 32'h1C00_0200; e.ecode = 6'h00;
        e.esub = 9'h000; e.vaddr = 32'h0;
        exp_q.push_back(e);
        e = idle_exp(); e.rdy = 0; e.fl = 1; e.flpc = 32'h1C00_8000;
        exp_q.push_back(e);
        exp_q.push_back(idle_exp());
        issue(3'd1, 14'h30, 32'h0, 32'hDEAD_BEEF, 32'h1C00_0200, 1'b1, 6'h09, 9'h1FF, 32'h0, 1'b1);
        check_cycle("int.t1");
        next_cycle();
        check_cycle("int.t2");
        next_cycle();
        check_cycle("int.t3");

        // ertn
        e = idle_exp(); e.rdy = 0; e.ertn = 1;
        exp_q.push_back(e);
        e = idle_exp(); e.rdy = 0; e.fl = 1; e.flpc = 32'h1C00_0204;
        exp_q.push_back(e);
        exp_q.push_back(idle_exp());
        issue(3'd3, 14'h6, 32'h0, 32'h0, 32'h1C00_0300, 1'b0, 6'h0, 9'h0, 32'h0, 1'b0);
        check_cycle("ertn.t1");
        next_cycle();
        check_cycle("ertn.t2");
        next_cycle();
        check_cycle("ertn.t3");

        // op 4 without exception: nothing happens
        exp_q.push_back(idle_exp());
        issue(3'd4, 14'h30, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1C00_0400, 1'b0, 6'h0, 9'h0, 32'h0, 1'b0);
        check_cycle("none.t1");

        // csrrd returns old value, no write
        csr_rvalue = 32'h0000_0077;
        e = idle_exp(); e.rdy = 0; e.re = 1; e.rfwe = 1; e.rfwd = 32'h0000_0077;
        exp_q.push_back(e);
        exp_q.push_back(idle_exp());
        issue(3'd0, 14'h30, 32'hFFFF_FFFF, 32'h5555_5555, 32'h1C00_0500, 1'b0, 6'h0, 9'h0, 32'h0, 1'b0);
        check_cycle("csrrd.t1");
        next_cycle();
        check_cycle("csrrd.t2");

        // reset during EXC drops the redirect
        e = idle_exp(); e.rdy = 0; e.wbex = 1; e.wbpc = 32'h1C00_0600; e.ecode = 6'h0A;
        e.esub = 9'h0; e.vaddr = 32'h0000_1234;
        exp_q.push_back(e);
        exp_q.push_back(idle_exp());
        exp_q.push_back(idle_exp());
        issue(3'd4, 14'h0, 32'h0, 32'h0, 32'h1C00_0600, 1'b1, 6'h0A, 9'h0, 32'h0000_1234, 1'b0);
        check_cycle("rst_exc.t1");
        resetn = 1'b0;
        next_cycle();
        check_cycle("rst_exc.t2");
        resetn = 1'b1;
        next_cycle();
        check_cycle("rst_exc.t3");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
